// File: rtl/wm_bus_if.sv
// Store-path bus between the MEM stage, the write controller and data memory.
// master = controller side, slave = pipeline/memory environment side.
`ifndef OpcodeWidth
`define OpcodeWidth 6
`endif
`ifndef RegDataWidth
`define RegDataWidth 32
`endif
`ifndef ByteSlctWidth
`define ByteSlctWidth 4
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif
`ifndef MIPS_SB
`define MIPS_SB 6'b101000
`endif
`ifndef MIPS_SH
`define MIPS_SH 6'b101001
`endif
`ifndef MIPS_SW
`define MIPS_SW 6'b101011
`endif

interface wm_bus_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                        st_valid;
  logic [`OpcodeWidth-1:0]     opcode;
  logic [ADDR_WIDTH-1:0]       addr;
  logic [`RegDataWidth-1:0]    store_data;
  logic                        mem_ack;
  logic                        mem_req;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [`ByteSlctWidth-1:0]   mem_byte_slct;
  logic [`RegDataWidth-1:0]    mem_wdata;
  logic                        stall_req;
  logic                        misalign_exc;

  modport master (
    input  st_valid, opcode, addr, store_data, mem_ack,
    output mem_req, mem_addr, mem_byte_slct, mem_wdata, stall_req, misalign_exc
  );

  modport slave (
    output st_valid, opcode, addr, store_data, mem_ack,
    input  mem_req, mem_addr, mem_byte_slct, mem_wdata, stall_req, misalign_exc
  );
endinterface

// File: rtl/wm_bus_ctrl.sv
// Store write controller: turns MEM-stage sb/sh/sw into a held, big-endian lane-aligned write.
// Define STORE_BUF_EN for posted writes (back-to-back accept on ack); default is blocking writes.
`ifndef OpcodeWidth
`define OpcodeWidth 6
`endif
`ifndef RegDataWidth
`define RegDataWidth 32
`endif
`ifndef ByteSlctWidth
`define ByteSlctWidth 4
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif
`ifndef MIPS_SB
`define MIPS_SB 6'b101000
`endif
`ifndef MIPS_SH
`define MIPS_SH 6'b101001
`endif
`ifndef MIPS_SW
`define MIPS_SW 6'b101011
`endif

module wm_bus_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  wm_bus_if.master bus
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                      state_reg, state_next;
  logic                        mem_req_reg;
  logic [ADDR_WIDTH-1:0]       mem_addr_reg;
  logic [`ByteSlctWidth-1:0]   mem_byte_slct_reg;
  logic [`RegDataWidth-1:0]    mem_wdata_reg;

  logic                        is_sb, is_sh, is_sw, is_store;
  logic                        misaligned, legal, accept, stall_raw;
  logic [`ByteSlctWidth-1:0]   lane_next;
  logic [`RegDataWidth-1:0]    wdata_next;

  assign is_sb      = (bus.opcode == `MIPS_SB);
  assign is_sh      = (bus.opcode == `MIPS_SH);
  assign is_sw      = (bus.opcode == `MIPS_SW);
  assign is_store   = is_sb | is_sh | is_sw;
  assign misaligned = (is_sh & bus.addr[0]) | (is_sw & (bus.addr[1:0] != 2'b00));
  assign legal      = bus.st_valid & is_store & ~misaligned;

  // Lane gi covers bits [8gi+7:8gi]; lane 3 holds the lowest byte address.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic       HI_HALF = (gi >= 2);
      localparam logic [1:0] SB_OFS  = 2'(3 - gi);
      assign lane_next[gi] = is_sw
                           | (is_sh & (bus.addr[1] != HI_HALF))
                           | (is_sb & (bus.addr[1:0] == SB_OFS));
      assign wdata_next[8*gi +: 8] = is_sb ? bus.store_data[7:0]
                                   : is_sh ? bus.store_data[8*(gi%2) +: 8]
                                   :         bus.store_data[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    stall_raw  = 1'b0;
`ifdef STORE_BUF_EN
    accept    = legal & ((state_reg == IDLE) | bus.mem_ack);
    stall_raw = legal & ~accept;
`else
    accept    = legal & (state_reg == IDLE);
    stall_raw = (state_reg == IDLE) ? legal : ~bus.mem_ack;
`endif
    case (state_reg)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (bus.mem_ack && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= IDLE;
      mem_req_reg       <= 1'b0;
      mem_addr_reg      <= '0;
      mem_byte_slct_reg <= '0;
      mem_wdata_reg     <= `ZeroWord;
    end else begin
      state_reg   <= state_next;
      mem_req_reg <= (state_next == BUSY);
      if (accept) begin
        mem_addr_reg      <= {bus.addr[ADDR_WIDTH-1:2], 2'b00};
        mem_byte_slct_reg <= lane_next;
        mem_wdata_reg     <= wdata_next;
      end
    end
  end

  assign bus.mem_req       = mem_req_reg;
  assign bus.mem_addr      = mem_addr_reg;
  assign bus.mem_byte_slct = mem_byte_slct_reg;
  assign bus.mem_wdata     = mem_wdata_reg;
  // Combinational flags are forced low while reset is asserted.
  assign bus.stall_req     = rst & stall_raw;
  assign bus.misalign_exc  = rst & bus.st_valid & misaligned;
endmodule

// File: tb/tb_wm_bus_ctrl.sv
// Randomized + directed bench for wm_bus_ctrl against a write-in-flight reference model.
`timescale 1ns/1ps
`ifndef MIPS_SB
`define MIPS_SB 6'b101000
`endif
`ifndef MIPS_SH
`define MIPS_SH 6'b101001
`endif
`ifndef MIPS_SW
`define MIPS_SW 6'b101011
`endif

module tb_wm_bus_ctrl;
  localparam int         AW     = 32;
  localparam logic [5:0] OP_SB  = `MIPS_SB;
  localparam logic [5:0] OP_SH  = `MIPS_SH;
  localparam logic [5:0] OP_SW  = `MIPS_SW;
  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
`ifdef STORE_BUF_EN
  localparam logic BUF = 1'b1;
`else
  localparam logic BUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wm_bus_if #(.ADDR_WIDTH(AW)) bus ();
  wm_bus_ctrl #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: at most one write in flight, plus the bus fields it must show.
  bit          m_pend  = 1'b0;
  bit          m_stall = 1'b0;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_lanes;

  function automatic logic [3:0] exp_lanes(logic [5:0] op, logic [1:0] a);
    if (op == OP_SB) return 4'b1000 >> a;
    if (op == OP_SH) return a[1] ? 4'b0011 : 4'b1100;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_data(logic [5:0] op, logic [31:0] d);
    if (op == OP_SB) return {4{d[7:0]}};
    if (op == OP_SH) return {2{d[15:0]}};
    return d;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    bit          st, mis, legal, acc, stall;
    logic [5:0]  op;
    logic [31:0] a;
    if (!rst) begin
      chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
      chk("rst_stall", {31'b0, bus.stall_req}, 32'd0);
      chk("rst_misalign", {31'b0, bus.misalign_exc}, 32'd0);
      m_pend  = 1'b0;
      m_stall = 1'b0;
    end else begin
      op    = bus.opcode;
      a     = bus.addr;
      st    = bus.st_valid && (op == OP_SB || op == OP_SH || op == OP_SW);
      mis   = st && ((op == OP_SH && a[0]) || (op == OP_SW && a[1:0] != 2'b00));
      legal = st && !mis;
      if (BUF) begin
        acc   = legal && (!m_pend || bus.mem_ack);
        stall = legal && !acc;
      end else begin
        acc   = legal && !m_pend;
        stall = m_pend ? !bus.mem_ack : legal;
      end
      chk("mem_req", {31'b0, bus.mem_req}, {31'b0, m_pend});
      if (m_pend) begin
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_byte_slct", {28'b0, bus.mem_byte_slct}, {28'b0, m_lanes});
        chk("mem_wdata", bus.mem_wdata, m_data);
      end
      chk("stall_req", {31'b0, bus.stall_req}, {31'b0, stall});
      chk("misalign_exc", {31'b0, bus.misalign_exc}, {31'b0, mis});
      m_stall = stall;
      if (acc) begin
        m_pend  = 1'b1;
        m_addr  = {a[31:2], 2'b00};
        m_lanes = exp_lanes(op, a[1:0]);
        m_data  = exp_data(op, bus.store_data);
      end else if (m_pend && bus.mem_ack) begin
        m_pend = 1'b0;
      end
    end
  end

  task automatic drive(bit v, logic [5:0] op, logic [31:0] a, logic [31:0] d, bit ack);
    bus.st_valid   = v;
    bus.opcode     = op;
    bus.addr       = a;
    bus.store_data = d;
    bus.mem_ack    = ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_bus(string name, bit req, logic [31:0] a, logic [3:0] l, logic [31:0] d);
    chk({name, "_req"}, {31'b0, bus.mem_req}, {31'b0, req});
    chk({name, "_addr"}, bus.mem_addr, a);
    chk({name, "_lanes"}, {28'b0, bus.mem_byte_slct}, {28'b0, l});
    chk({name, "_wdata"}, bus.mem_wdata, d);
  endtask

  initial begin
    logic [5:0] op;
    drive(0, OP_NOP, 0, 0, 0);

    chk("fn_sb_lane", {28'b0, exp_lanes(OP_SB, 2'b11)}, 32'h1);
    chk("fn_sh_lane", {28'b0, exp_lanes(OP_SH, 2'b10)}, 32'h3);
    chk("fn_sb_data", exp_data(OP_SB, 32'h123456AB), 32'hABABABAB);
    chk("fn_sh_data", exp_data(OP_SH, 32'h0000BEEF), 32'hBEEFBEEF);

    repeat (3) step();
    probe();
    chk_bus("reset", 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    rst = 1'b1;

    // sb to the last byte of a word
    step(); drive(1, OP_SB, 32'h1003, 32'h123456AB, 0);
    probe(); chk("sb_accept_stall", {31'b0, bus.stall_req}, {31'b0, !BUF});
    step(); drive(0, OP_NOP, 0, 0, 0);
    probe(); chk_bus("sb", 1'b1, 32'h1000, 4'b0001, 32'hABABABAB);
    step(); drive(0, OP_NOP, 0, 0, 1);
    step(); drive(0, OP_NOP, 0, 0, 0);
    probe(); chk("sb_done_req", {31'b0, bus.mem_req}, 32'd0);

    // sh to upper half with a late ack
    step(); drive(1, OP_SH, 32'h2002, 32'h0000BEEF, 0);
    probe(); chk("sh_accept_stall", {31'b0, bus.stall_req}, {31'b0, !BUF});
    for (int i = 0; i < 3; i++) begin
      step();
      if (BUF) drive(0, OP_NOP, 0, 0, i == 2);
      else     drive(1, OP_SH, 32'h2002, 32'h0000BEEF, i == 2);
      probe();
      chk_bus("sh_hold", 1'b1, 32'h2000, 4'b0011, 32'hBEEFBEEF);
      chk("sh_hold_stall", {31'b0, bus.stall_req}, {31'b0, (!BUF && i < 2)});
    end
    step(); drive(0, OP_NOP, 0, 0, 0);
    probe(); chk("sh_done_req", {31'b0, bus.mem_req}, 32'd0);

    // misaligned sw
    step(); drive(1, OP_SW, 32'h0006, 32'hCAFEF00D, 0);
    probe();
    chk("mis_exc", {31'b0, bus.misalign_exc}, 32'd1);
    chk("mis_stall", {31'b0, bus.stall_req}, 32'd0);
    step(); drive(0, OP_NOP, 0, 0, 0);
    probe(); chk("mis_req", {31'b0, bus.mem_req}, 32'd0);

`ifdef STORE_BUF_EN
    // back-to-back posted writes
    step(); drive(1, OP_SW, 32'h0100, 32'h11111111, 0);
    probe(); chk("b2b_stall0", {31'b0, bus.stall_req}, 32'd0);
    step(); drive(1, OP_SW, 32'h0104, 32'h22222222, 1);
    probe(); chk_bus("b2b_first", 1'b1, 32'h0100, 4'hF, 32'h11111111);
    chk("b2b_stall1", {31'b0, bus.stall_req}, 32'd0);
    step(); drive(0, OP_NOP, 0, 0, 0);
    probe(); chk_bus("b2b_second", 1'b1, 32'h0104, 4'hF, 32'h22222222);
    step(); drive(0, OP_NOP, 0, 0, 1);
    step(); drive(0, OP_NOP, 0, 0, 0);
    probe(); chk("b2b_done_req", {31'b0, bus.mem_req}, 32'd0);
`endif

    // reset in the middle of a write
    step(); drive(1, OP_SW, 32'h0300, 32'hA5A5A5A5, 0);
    step(); drive(0, OP_NOP, 0, 0, 0);
    probe(); chk("rb_busy_req", {31'b0, bus.mem_req}, 32'd1);
    rst = 1'b0;
    drive(1, OP_SW, 32'h0300, 32'hA5A5A5A5, 0);
    #1;
    chk_bus("rb_async", 1'b0, 32'h0, 4'h0, 32'h0);
    chk("rb_stall", {31'b0, bus.stall_req}, 32'd0);
    step(); drive(1, OP_SW, 32'h0302, 32'h0, 0);
    probe(); chk("rb_exc", {31'b0, bus.misalign_exc}, 32'd0);
    step(); rst = 1'b1; drive(0, OP_NOP, 0, 0, 0);
    step(); drive(1, OP_SW, 32'h0040, 32'hDEADBEEF, 0);
    step(); drive(0, OP_NOP, 0, 0, 0);
    probe(); chk_bus("rb_after", 1'b1, 32'h0040, 4'hF, 32'hDEADBEEF);
    step(); drive(0, OP_NOP, 0, 0, 1);
    step(); drive(0, OP_NOP, 0, 0, 0);

    // randomized traffic; a stalled instruction is usually held like a real pipeline
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst = 1'b0;
      bus.mem_ack = ($urandom_range(0, 9) < 4);
      if (!(m_stall && $urandom_range(0, 3) != 0)) begin
        case ($urandom_range(0, 4))
          0: op = OP_SB;
          1: op = OP_SH;
          2: op = OP_SW;
          default: begin
            op = 6'($urandom);
            if (op == OP_SB || op == OP_SH || op == OP_SW) op = OP_LW;
          end
        endcase
        bus.st_valid   = ($urandom_range(0, 9) < 7);
        bus.opcode     = op;
        bus.addr       = $urandom;
        bus.store_data = $urandom;
      end
    end
    step();
    drive(0, OP_NOP, 0, 0, 0);
    probe();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
